// File: rtl/clock_gen_arbiter_if.sv
// Bundles the requester handshake and the clock-generator start/busy pair shared
// by clock_gen_arbiter and whatever drives it.
interface clock_gen_arbiter_if #(
  parameter int NUM_REQ = 2
);
  // Handshake: req[i] is a level held by requester i until it sees done with gnt[i]
  // set; gnt is one-hot for the whole burst, done/err pulse for one cycle at its
  // end, and gen_start is a single-cycle pulse answered by the generator's gen_busy.
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic               done;
  logic               err;
  logic               busy;
  logic               gen_start;
  logic               gen_busy;

  modport master (
    output req,
    output gen_busy,
    input  gnt,
    input  done,
    input  err,
    input  busy,
    input  gen_start
  );

  modport slave (
    input  req,
    input  gen_busy,
    output gnt,
    output done,
    output err,
    output busy,
    output gen_start
  );
endinterface

// File: rtl/clock_gen_arbiter.sv
// Round-robin sharing of one burst clock generator between NUM_REQ requesters,
// with a start timeout when the generator never reports busy.
module clock_gen_arbiter #(
  parameter int NUM_REQ       = 2,
  parameter int START_TIMEOUT = 4
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  clock_gen_arbiter_if.slave    bus,
  output logic [2:0]            state_dbg
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(START_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_RUN       = 3'd3,
    S_DONE      = 3'd4
  } state_e;

  state_e             state_q, state_n;
  logic [NUM_REQ-1:0] gnt_q, gnt_n;
  logic               start_q, start_n;
  logic               done_q, done_n;
  logic               err_q, err_n;
  logic               busy_q, busy_n;
  logic [PW-1:0]      last_q, last_n;
  logic [CW-1:0]      cnt_q, cnt_n;

  logic               pick_found;
  logic [PW-1:0]      pick_idx;

  // Scan upward from the requester after the last grant, wrapping around.
  always_comb begin : rr_scan
    int            idx;
    logic [PW-1:0] idx_v;
    pick_found = 1'b0;
    pick_idx   = '0;
    idx        = 0;
    idx_v      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_v = idx[PW-1:0];
      if (!pick_found && bus.req[idx_v]) begin
        pick_found = 1'b1;
        pick_idx   = idx_v;
      end
    end
  end

  always_comb begin
    state_n = state_q;
    gnt_n   = gnt_q;
    start_n = 1'b0;
    done_n  = 1'b0;
    err_n   = 1'b0;
    busy_n  = busy_q;
    last_n  = last_q;
    cnt_n   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          state_n          = S_START;
          gnt_n            = '0;
          gnt_n[pick_idx]  = 1'b1;
          start_n          = 1'b1;
          busy_n           = 1'b1;
          last_n           = pick_idx;
        end
      end
      S_START: begin
        state_n = S_WAIT_BUSY;
        cnt_n   = '0;
      end
      S_WAIT_BUSY: begin
        if (bus.gen_busy) begin
          state_n = S_RUN;
        end else begin
          cnt_n = cnt_q + 1'b1;
          if (cnt_n == CW'(START_TIMEOUT)) begin
            state_n = S_DONE;
            done_n  = 1'b1;
            err_n   = 1'b1;
          end
        end
      end
      S_RUN: begin
        // Any low cycle ends the burst; the generator's busy is trusted as-is.
        if (!bus.gen_busy) begin
          state_n = S_DONE;
          done_n  = 1'b1;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
        gnt_n   = '0;
        busy_n  = 1'b0;
      end
      default: begin
        state_n = S_IDLE;
        gnt_n   = '0;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      last_q  <= PW'(NUM_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      gnt_q   <= gnt_n;
      start_q <= start_n;
      done_q  <= done_n;
      err_q   <= err_n;
      busy_q  <= busy_n;
      last_q  <= last_n;
      cnt_q   <= cnt_n;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gen_start = start_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.busy      = busy_q;
  assign state_dbg     = state_q;

endmodule
